// File: rtl/red_xor_seq_pkg.sv
// red_xor_seq_pkg: FSM state type and width helpers shared by red_xor_seq
package red_xor_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic int cnt_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/red_xor_seq_red_xor.sv
// RedXor: single-cycle XOR reduction of one chunk
module RedXor #(
    parameter int width = 8
) (
    input  logic [width-1:0] A,
    output logic             Z
);

    assign Z = ^A;

endmodule

// File: rtl/red_xor_seq.sv
// red_xor_seq: arbitrated, chunk-serial parity engine around one shared RedXor.
// Define RED_XOR_SEQ_RR_EN for round-robin arbitration; fixed priority otherwise.
module red_xor_seq
    import red_xor_seq_pkg::*;
#(
    parameter int width  = 8,
    parameter int chunks = 4,
    parameter int nreq   = 2
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [nreq-1:0]                 ReqValid,
    output logic [nreq-1:0]                 ReqReady,
    input  logic [nreq*width*chunks-1:0]    ReqData,
    output logic                            ResValid,
    input  logic                            ResReady,
    output logic                            ResParity,
    output logic [id_width(nreq)-1:0]       ResId
);

    localparam int W  = width * chunks;
    localparam int CW = cnt_width(chunks);
    localparam int IW = id_width(nreq);

    state_e          r_state;
    state_e          w_nxt;
    logic [W-1:0]    r_data;
    logic [IW-1:0]   r_id;
    logic            r_acc;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   w_gnt;
    logic [W-1:0]    w_word;
    logic [width-1:0] w_a;
    logic            w_z;
    logic            w_any;
    logic            w_take;
    logic            w_last;

`ifdef RED_XOR_SEQ_RR_EN
    logic [IW-1:0]   r_ptr;
`endif

    RedXor #(.width(width)) u_red_xor (
        .A(w_a),
        .Z(w_z)
    );

    // Pick the valid requester with the smallest distance from the search start
    always_comb begin
        int w_best;
        int w_off;
        w_gnt  = '0;
        w_word = ReqData[W-1:0];
        w_best = nreq;
        w_off  = 0;
        for (int j = 0; j < nreq; j++) begin
`ifdef RED_XOR_SEQ_RR_EN
            w_off = (j + nreq - int'(r_ptr)) % nreq;
`else
            w_off = j;
`endif
            if (ReqValid[j] && w_off < w_best) begin
                w_best = w_off;
                w_gnt  = IW'(j);
                w_word = ReqData[j*W +: W];
            end
        end
    end

    assign w_any    = |ReqValid;
    assign w_take   = (r_state == IDLE) && w_any && !RST;
    assign w_last   = (r_cnt == CW'(chunks - 1));
    assign ResValid = (r_state == DONE);
    assign ResParity = r_acc;
    assign ResId    = r_id;

    // One-hot ready for the granted requester, only while idle and out of reset
    always_comb begin
        ReqReady = '0;
        for (int j = 0; j < nreq; j++)
            ReqReady[j] = w_take && (w_gnt == IW'(j));
    end

    // Present the current chunk of the captured word to the shared reducer
    always_comb begin
        w_a = r_data[width-1:0];
        for (int c = 0; c < chunks; c++)
            if (r_cnt == CW'(c)) w_a = r_data[c*width +: width];
    end

    // Next-state logic
    always_comb begin
        w_nxt = (r_state == IDLE) ? (w_take ? RUN : IDLE) :
                (r_state == RUN)  ? (w_last ? DONE : RUN) :
                (ResReady ? IDLE : DONE);
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_nxt;
    end

    // Capture on grant, then fold one chunk per RUN cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_data <= '0;
            r_id   <= '0;
            r_acc  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_take) begin
            r_data <= w_word;
            r_id   <= w_gnt;
            r_acc  <= 1'b0;
            r_cnt  <= '0;
        end else if (r_state == RUN) begin
            r_acc <= r_acc ^ w_z;
            if (!w_last) r_cnt <= r_cnt + CW'(1);
        end
    end

`ifdef RED_XOR_SEQ_RR_EN
    // Round-robin start moves past the winner once its result is consumed
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                                r_ptr <= '0;
        else if (r_state == DONE && ResReady)   r_ptr <= IW'((int'(r_id) + 1) % nreq);
    end
`endif

endmodule

// File: tb/tb_red_xor_seq.sv
// tb_red_xor_seq: randomized self-checking bench for red_xor_seq against a word-level model
module tb_red_xor_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  ReqValid = '0;
    logic [1:0]  ReqReady;
    logic [63:0] ReqData = '0;
    logic        ResValid;
    logic        ResReady = 1'b1;
    logic        ResParity;
    logic [0:0]  ResId;

    logic        v2 = 1'b0;
    logic [0:0]  rdy2;
    logic [31:0] d2 = '0;
    logic        rv2;
    logic        rr2 = 1'b1;
    logic        rp2;
    logic [0:0]  rid2;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    always #5 CLK = ~CLK;

    red_xor_seq dut (
        .CLK(CLK), .RST(RST), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqData(ReqData),
        .ResValid(ResValid), .ResReady(ResReady), .ResParity(ResParity), .ResId(ResId)
    );

    red_xor_seq #(.width(32), .chunks(1), .nreq(1)) dut2 (
        .CLK(CLK), .RST(RST), .ReqValid(v2), .ReqReady(rdy2), .ReqData(d2),
        .ResValid(rv2), .ResReady(rr2), .ResParity(rp2), .ResId(rid2)
    );

    // Word-level arbitration model
    function automatic int model_grant(input logic [1:0] m);
        for (int k = 0; k < 2; k++) begin
            int j;
`ifdef RED_XOR_SEQ_RR_EN
            j = (m_ptr + k) % 2;
`else
            j = k;
`endif
            if (m[j]) return j;
        end
        return -1;
    endfunction

    // Issue one request and follow it to ResValid; timeouts come back as -1
    task automatic run_txn(input logic [1:0] mask, input logic [31:0] d0, input logic [31:0] d1,
                           output int g, output int lat, output logic par, output int id,
                           output int leak, output time hs);
        g = -1; lat = -1; par = 1'bx; id = -1; leak = 0; hs = 0;
        ReqData  = {d1, d0};
        ReqValid = mask;
        #1;
        for (int c = 0; c < 20 && ReqReady == 2'b00; c++) begin
            @(posedge CLK); #2;
        end
        g = (ReqReady == 2'b01) ? 0 : (ReqReady == 2'b10) ? 1 : -1;
        if (g < 0) begin
            ReqValid = '0;
            return;
        end
        @(posedge CLK);
        hs = $time;
        #1;
        ReqData = {$urandom, $urandom};
        for (int c = 1; c <= 20; c++) begin
            if (ResValid) begin
                lat = c;
                break;
            end
            if (ReqReady != 2'b00) leak++;
            @(posedge CLK); #1;
        end
        par = ResParity;
        id  = int'(ResId);
        ReqValid = '0;
    endtask

    task automatic consume(input int g);
        ResReady = 1'b1;
        @(posedge CLK); #1;
        m_ptr = (g + 1) % 2;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        ReqValid = 2'b11;
        v2 = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (ReqReady !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", ReqReady); end
        checks++; if (ResValid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", ResValid); end
        checks++; if (ResParity !== 1'b0) begin errors++; $display("FAIL reset_parity got %b want 0", ResParity); end
        checks++; if (ResId !== 1'b0) begin errors++; $display("FAIL reset_id got %0d want 0", ResId); end
        checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL reset_req_ready2 got %b want 0", rdy2); end
        ReqValid = '0;
        v2 = 1'b0;
        RST = 1'b0;
        m_ptr = 0;
        @(posedge CLK); #1;
    endtask

    task automatic test_basic();
        int g, lat, id, leak; logic par; time hs;
        ResReady = 1'b1;
        run_txn(2'b01, 32'h0000_0001, 32'h0, g, lat, par, id, leak, hs);
        checks++; if (g !== 0) begin errors++; $display("FAIL basic_grant got %0d want 0", g); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got %0d want 5", lat); end
        checks++; if (par !== 1'b1) begin errors++; $display("FAIL basic_parity got %b want 1", par); end
        checks++; if (id !== 0) begin errors++; $display("FAIL basic_id got %0d want 0", id); end
        checks++; if (leak !== 0) begin errors++; $display("FAIL basic_ready_pulse extra ready cycles %0d want 0", leak); end
        consume(g);
    endtask

    task automatic test_req1();
        int g, lat, id, leak; logic par; time hs;
        logic [31:0] words [2] = '{32'hFFFF_FFFF, 32'h8000_0000};
        logic        want  [2] = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            run_txn(2'b10, 32'h1234_5678, words[i], g, lat, par, id, leak, hs);
            checks++; if (par !== want[i]) begin errors++; $display("FAIL req1_parity[%0d] got %b want %b", i, par, want[i]); end
            checks++; if (id !== 1) begin errors++; $display("FAIL req1_id[%0d] got %0d want 1", i, id); end
            consume(g);
        end
    endtask

    task automatic test_back_to_back();
        int g, lat, id, leak, exp_g; logic par; time hs, prev;
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            exp_g = model_grant(2'b11);
            run_txn(2'b11, 32'h0000_0003, 32'h0000_0001, g, lat, par, id, leak, hs);
            checks++; if (g !== exp_g) begin errors++; $display("FAIL b2b_grant[%0d] got %0d want %0d", i, g, exp_g); end
            checks++; if (id !== exp_g) begin errors++; $display("FAIL b2b_id[%0d] got %0d want %0d", i, id, exp_g); end
            if (i > 0) begin
                checks++; if (hs - prev !== 60) begin errors++; $display("FAIL b2b_period[%0d] got %0t want 60", i, hs - prev); end
            end
            prev = hs;
            consume(g);
        end
    endtask

    task automatic test_stall();
        int g, lat, id, leak, exp_g, bad; logic par, exp_p;
        time hs;
        logic [31:0] d0, d1;
        d0 = $urandom; d1 = $urandom;
        exp_g = model_grant(2'b11);
        exp_p = (exp_g == 0) ? ^d0 : ^d1;
        ResReady = 1'b0;
        run_txn(2'b11, d0, d1, g, lat, par, id, leak, hs);
        checks++; if (par !== exp_p) begin errors++; $display("FAIL stall_parity got %b want %b", par, exp_p); end
        bad = 0;
        ReqValid = 2'b11;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK); #1;
            if (ResValid !== 1'b1 || ResParity !== exp_p || int'(ResId) !== exp_g || ReqReady !== 2'b00) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_hold unstable cycles %0d want 0", bad); end
        consume(exp_g);
        checks++; if (ResValid !== 1'b0) begin errors++; $display("FAIL stall_release_valid got %b want 0", ResValid); end
        checks++; if (ReqReady !== 2'(1 << model_grant(2'b11))) begin errors++; $display("FAIL stall_release_ready got %b want %b", ReqReady, 2'(1 << model_grant(2'b11))); end
        ReqValid = '0;
        @(posedge CLK); #1;
        for (int c = 0; c < 10 && !ResValid; c++) begin @(posedge CLK); #1; end
        consume(model_grant(2'b11));
    endtask

    task automatic test_reset_mid_run();
        int g, lat, id, leak, exp_g, seen; logic par; time hs;
        run_txn(2'b01, 32'h0, 32'h0, g, lat, par, id, leak, hs);
        consume(g);
        ReqValid = 2'b10;
        ReqData = {32'hFFFF_FFFE, 32'h0};
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1;
        ReqValid = 2'b11;
        #1;
        checks++; if (ResValid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", ResValid); end
        checks++; if (ReqReady !== 2'b00) begin errors++; $display("FAIL midrst_ready got %b want 00", ReqReady); end
        checks++; if (ResParity !== 1'b0 || ResId !== 1'b0) begin errors++; $display("FAIL midrst_outputs got %b/%0d want 0/0", ResParity, ResId); end
        @(posedge CLK); #1;
        RST = 1'b0;
        m_ptr = 0;
        ReqValid = '0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge CLK); #1;
            if (ResValid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_result got %0d valid cycles want 0", seen); end
        exp_g = model_grant(2'b11);
        run_txn(2'b11, 32'h0, 32'h1, g, lat, par, id, leak, hs);
        checks++; if (g !== exp_g) begin errors++; $display("FAIL midrst_grant got %0d want %0d", g, exp_g); end
        consume(g);
    endtask

    task automatic test_random();
        int g, lat, id, leak, exp_g, stall; logic par, exp_p; time hs;
        logic [1:0]  mask;
        logic [31:0] d0, d1;
        for (int i = 0; i < 30; i++) begin
            mask  = 2'($urandom_range(1, 3));
            d0    = $urandom; d1 = $urandom;
            stall = $urandom_range(0, 3);
            exp_g = model_grant(mask);
            exp_p = (exp_g == 0) ? ^d0 : ^d1;
            ResReady = (stall == 0);
            run_txn(mask, d0, d1, g, lat, par, id, leak, hs);
            checks++; if (g !== exp_g) begin errors++; $display("FAIL rand_grant[%0d] got %0d want %0d", i, g, exp_g); end
            checks++; if (par !== exp_p) begin errors++; $display("FAIL rand_parity[%0d] got %b want %b", i, par, exp_p); end
            checks++; if (id !== exp_g) begin errors++; $display("FAIL rand_id[%0d] got %0d want %0d", i, id, exp_g); end
            checks++; if (lat !== 5 || leak !== 0) begin errors++; $display("FAIL rand_timing[%0d] got lat %0d leak %0d want 5 0", i, lat, leak); end
            repeat (stall) begin @(posedge CLK); #1; end
            consume(exp_g);
        end
    endtask

    task automatic test_single_chunk();
        logic [31:0] d;
        int lat;
        for (int i = 0; i < 5; i++) begin
            d = (i == 0) ? 32'h0000_0007 : $urandom;
            lat = -1;
            v2 = 1'b1;
            d2 = d;
            #1;
            checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL c1_ready[%0d] got %b want 1", i, rdy2); end
            @(posedge CLK); #1;
            v2 = 1'b0;
            d2 = $urandom;
            for (int c = 1; c <= 10; c++) begin
                if (rv2) begin lat = c; break; end
                @(posedge CLK); #1;
            end
            checks++; if (lat !== 2) begin errors++; $display("FAIL c1_latency[%0d] got %0d want 2", i, lat); end
            checks++; if (rp2 !== ^d || rid2 !== 1'b0) begin errors++; $display("FAIL c1_result[%0d] got %b/%0d want %b/0", i, rp2, rid2, ^d); end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_req1();
        test_back_to_back();
        test_stall();
        test_reset_mid_run();
        test_random();
        test_single_chunk();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/red_xor_seq.md
# red_xor_seq

Sequenced, shared parity engine. Up to `nreq` requesters each present a wide word of `width*chunks` bits. One `RedXor` instance of `width` bits is time-shared: the block arbitrates between requesters, captures the granted word, and folds it through `RedXor` one chunk per cycle. It returns the parity together with the requester index over a valid/ready handshake. It sits between parity/ECC clients and the arithmetic library's reduction datapath.

## Interface
- `width`, 8, chunk width in bits; this is the width of the shared `RedXor`.
- `chunks`, 4, chunks per word; ≥1.
- `nreq`, 2, number of requesters; ≥1.
- `CLK` in 1: clock. All state changes on the rising edge.
- `RST` in 1: reset. Asynchronous, active-high.
- `ReqValid` in `nreq`: request valid, one bit per requester.
- `ReqReady` out `nreq`: request accepted. One-hot or zero.
- `ReqData` in `nreq*width*chunks`: flattened words. Requester i occupies bits [(i+1)*W-1 : i*W], with W = width*chunks.
- `ResValid` out 1: result valid.
- `ResReady` in 1: result consumed.
- `ResParity` out 1: XOR of all W bits of the granted word.
- `ResId` out max(1,$clog2(nreq)): index of the granted requester.

## Operation
- FSM states:
  - IDLE (reset state): accepts requests.
  - RUN: folds the captured word chunk by chunk.
  - DONE: holds the result until the consumer takes it.
- IDLE:
  - If any `ReqValid` is high, the arbiter selects index g.
  - `ReqReady[g]` is high in the same cycle (combinational from `ReqValid`).
  - On that edge: word g is captured into the data register, g into the id register, and the accumulator and chunk counter are cleared. Next state is RUN.
  - If no request is valid, the FSM stays in IDLE.
- RUN, chunk counter k from 0 to chunks-1:
  - `RedXor.A` = bits [(k+1)*width-1 : k*width] of the captured word. Chunk 0 is the LSB chunk.
  - Accumulator ^= `RedXor.Z`; k increments.
  - On the edge where k = chunks-1, the FSM moves to DONE.
  - The counter is $clog2(chunks) bits wide, minimum 1, and never wraps past chunks-1.
- DONE:
  - `ResValid` is high; `ResParity` = accumulator and `ResId` = id register, both stable.
  - When `ResReady` is high: next state is IDLE and the arbiter pointer updates.
  - While waiting, `ResReady` low holds all outputs and `ReqReady` = 0.
- `ReqReady` is 0 in RUN and DONE.
- `ReqData` and `ReqValid` changes after capture are ignored.
- A requester may drop `ReqValid` before it is granted; no request is lost or duplicated.
- `nreq`=1: `ResId` is constant 0 and the arbiter degenerates to a pass-through.
- Reset:
  - Values while `RST` is high: FSM = IDLE; `ReqReady` = 0 (forced, even if `ReqValid` is high); `ResValid` = 0; `ResParity` = 0; `ResId` = 0; accumulator = 0; counter = 0; arbiter pointer = 0.
  - Reset during RUN or DONE aborts the operation. No result is emitted.

## Timing
- Request handshake at edge t. RUN occupies cycles t+1 … t+chunks. `ResValid` rises at the start of cycle t+chunks+1.
- Latency from request handshake to `ResValid`: chunks+1 cycles.
- Minimum period between accepted requests: chunks+2 cycles, with `ResReady` tied high.
- `ResValid`/`ResParity`/`ResId` are registered. `ReqReady` is combinational from the FSM state and `ReqValid`.

## Configuration
- Macro `RED_XOR_SEQ_RR_EN` selects the arbitration policy.
- Defined (round-robin):
  - The search starts at (last granted index + 1) mod nreq.
  - The pointer updates on the result handshake.
- Undefined (fixed priority):
  - The lowest valid index always wins.
  - No pointer register exists.

## Structure
- Package `red_xor_seq_pkg` holds:
  - `state_e` typedef (IDLE, RUN, DONE);
  - a function computing the counter width, max(1, $clog2(chunks));
  - a function computing the id width, max(1, $clog2(nreq)).
- Sub-module: the library `RedXor` with `width` = width. It is the only datapath instance.
- Arbitration, FSM, counter and accumulator are inline.

## Test plan
- Defaults. Requester 0 sends 32'h0000_0001; `ResReady`=1.
  - `ReqReady[0]` pulses one cycle.
  - `ResValid` rises 5 cycles after the handshake with `ResParity`=1 and `ResId`=0.
- Requester 1 sends 32'hFFFF_FFFF, then 32'h8000_0000.
  - First result: `ResParity`=0, `ResId`=1.
  - Second result: `ResParity`=1, `ResId`=1.
- Both `ReqValid` held high for 3 requests:
  - With `RED_XOR_SEQ_RR_EN`: grants 0, 1, 0.
  - Without it: grants 0, 0, 0.
- In DONE, hold `ResReady`=0 for 10 cycles.
  - `ResValid`, `ResParity` and `ResId` stay stable.
  - `ReqReady`=0 throughout.
  - One cycle after `ResReady`=1, the FSM is in IDLE and accepts the next request.
- Assert `RST` in the 2nd RUN cycle.
  - Immediately: `ResValid`=0 and `ReqReady`=0.
  - After release, a new request from requester 1 with `ReqValid`=2'b11 is granted to index 0 (pointer reset).
- Configuration `chunks`=1, `width`=32, data 32'h0000_0007.
  - `ResValid` arrives 2 cycles after the handshake with `ResParity`=1.
